// File: rtl/rvc_asap_fpga_in_debounce.sv
// ----------------------------------------------------------------------------
// rvc_asap_fpga_in_debounce
//
// Conditions the raw FPGA board inputs (KEY buttons and slide switches) before
// the memory wrapper exposes them as CR_MEM readable registers.
//
// There are twelve identical channels:
//   - channel 0 is KEY0
//   - channel 1 is KEY1
//   - channels 2..11 are Switch[0..9]
// Each channel has a 2-flop synchronizer and a stable register `stab`.
// When RVC_ASAP_DEBOUNCE_EN is defined, each channel also has a stability
// counter.
//
// Button channels are inverted at the synchronizer input. This makes all
// internal state active-high (1 = pressed).
//
// Configuration macro: RVC_ASAP_DEBOUNCE_EN
//   defined   : `stab` follows the synchronized input only after
//               DEBOUNCE_CYCLES consecutive differing samples.
//   undefined : the counters are removed and `stab` follows the synchronized
//               input every cycle. The parameters then have no effect.
//
// Ports
//   Clock        core clock (single domain)
//   Rst          asynchronous active-high reset
//   RawButton_0  KEY0 pin, active-low, asynchronous
//   RawButton_1  KEY1 pin, active-low, asynchronous
//   RawSwitch    slide switch pins, active-high, asynchronous
//   EventClr     per-bit clear strobe for ButtonEvent (CR write)
//   Button_0     debounced KEY0, active-high
//   Button_1     debounced KEY1, active-high
//   Switch       debounced switches
//   ButtonEvent  sticky press flags, set on a debounced rising edge
// ----------------------------------------------------------------------------
module rvc_asap_fpga_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       RawButton_0,
    input  logic       RawButton_1,
    input  logic [9:0] RawSwitch,
    input  logic [1:0] EventClr,
    output logic       Button_0,
    output logic       Button_1,
    output logic [9:0] Switch,
    output logic [1:0] ButtonEvent
);

    localparam int NCH = 12;

    // Reject configurations whose counter cannot reach DEBOUNCE_CYCLES-1.
    // The check also applies when the counter is compiled out, so a parameter
    // set that builds today keeps building once the macro is enabled.
    if ((DEBOUNCE_CYCLES < 2) || (CNT_WIDTH < 1) ||
        ((64'd1 << CNT_WIDTH) < 64'(DEBOUNCE_CYCLES))) begin : g_illegal_config
        $error("rvc_asap_fpga_in_debounce: illegal DEBOUNCE_CYCLES/CNT_WIDTH");
    end

    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] sync1_r;
    logic [NCH-1:0] sync2_r;
    logic [NCH-1:0] stab_r;
    logic [NCH-1:0] stab_next_s;
    logic [1:0]     event_r;
    logic [1:0]     event_next_s;

    // Invert the buttons here so every channel is active-high from here on.
    assign raw_s = {RawSwitch, ~RawButton_1, ~RawButton_0};

    // Two-flop synchronizer. It resets to the released (0) value.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            sync1_r <= {NCH{1'b0}};
            sync2_r <= {NCH{1'b0}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

`ifdef RVC_ASAP_DEBOUNCE_EN
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_r      [NCH];
    logic [CNT_WIDTH-1:0] cnt_next_s [NCH];

    // Per-channel stability FSM.
    // Any sample equal to `stab` restarts the count, so only an unbroken run
    // of DEBOUNCE_CYCLES differing samples moves the output. Because the
    // counter is cleared on the transition, it never passes CNT_LAST.
    always_comb begin
        stab_next_s = stab_r;
        for (int i = 0; i < NCH; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sync2_r[i] == stab_r[i]) begin
                cnt_next_s[i] = {CNT_WIDTH{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stab_next_s[i] = sync2_r[i];
                cnt_next_s[i]  = {CNT_WIDTH{1'b0}};
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Stability counters.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end
`else
    // No debounce: the stable value follows the synchronizer every cycle.
    always_comb begin
        stab_next_s = sync2_r;
    end
`endif

    // Sticky press flags.
    // A 0->1 transition of `stab` on this edge sets the flag; the set wins
    // over a simultaneous clear. Releases never touch the flag.
    always_comb begin
        event_next_s = event_r;
        for (int i = 0; i < 2; i++) begin
            if (stab_next_s[i] && !stab_r[i]) begin
                event_next_s[i] = 1'b1;
            end else if (EventClr[i]) begin
                event_next_s[i] = 1'b0;
            end else begin
                event_next_s[i] = event_r[i];
            end
        end
    end

    // Stable values and event flags. These registers drive the outputs.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            stab_r  <= {NCH{1'b0}};
            event_r <= 2'b00;
        end else begin
            stab_r  <= stab_next_s;
            event_r <= event_next_s;
        end
    end

    assign Button_0    = stab_r[0];
    assign Button_1    = stab_r[1];
    assign Switch      = stab_r[11:2];
    assign ButtonEvent = event_r;

endmodule

// File: tb/tb_rvc_asap_fpga_in_debounce.sv
// ----------------------------------------------------------------------------
// Testbench for rvc_asap_fpga_in_debounce.
//
// The DUT runs with DEBOUNCE_CYCLES=4 and CNT_WIDTH=3. Raw inputs are
// registered before edge E. The outputs change after edge E+LAT, where:
//   LAT = 1+DEBOUNCE_CYCLES  when RVC_ASAP_DEBOUNCE_EN is defined
//   LAT = 2                  when it is not defined
// ----------------------------------------------------------------------------
module tb_rvc_asap_fpga_in_debounce;

    localparam int DC = 4;
    localparam int CW = 3;
`ifdef RVC_ASAP_DEBOUNCE_EN
    localparam int LAT = DC + 1;
`else
    localparam int LAT = 2;
`endif

    logic       Clock = 1'b0;
    logic       Rst   = 1'b1;
    logic       RawButton_0;
    logic       RawButton_1;
    logic [9:0] RawSwitch;
    logic [1:0] EventClr;
    logic       Button_0;
    logic       Button_1;
    logic [9:0] Switch;
    logic [1:0] ButtonEvent;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        b0n;
        logic        b1n;
        logic [9:0]  sw;
        logic [1:0]  clr;
        int          n;
        logic [13:0] exp;   // {Button_0, Button_1, Switch, ButtonEvent}
    } vec_t;

    vec_t tbl [17];

    rvc_asap_fpga_in_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (CW)
    ) dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .RawButton_0(RawButton_0),
        .RawButton_1(RawButton_1),
        .RawSwitch  (RawSwitch),
        .EventClr   (EventClr),
        .Button_0   (Button_0),
        .Button_1   (Button_1),
        .Switch     (Switch),
        .ButtonEvent(ButtonEvent)
    );

    always #5 Clock = ~Clock;

    function automatic logic [13:0] outs();
        return {Button_0, Button_1, Switch, ButtonEvent};
    endfunction

    // Advance past one active edge and settle away from it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%h, expected 'h%h", name, act, exp);
        end
    endtask

    initial begin
        int pat [8];
        pat = '{1, 0, 1, 0, 0, 0, 0, 0};

        // Fields: b0n, b1n, sw, clr, cycles, expected {b0, b1, sw, ev}.
        // Start: b0 pressed, switches 3FF, ev=01.
        tbl[0]  = '{1'b0, 1'b1, 10'h3FF, 2'b01, 1,       {1'b1, 1'b0, 10'h3FF, 2'b00}};
        tbl[1]  = '{1'b0, 1'b1, 10'h000, 2'b00, LAT,     {1'b1, 1'b0, 10'h3FF, 2'b00}};
        tbl[2]  = '{1'b0, 1'b1, 10'h000, 2'b00, 1,       {1'b1, 1'b0, 10'h000, 2'b00}};
        tbl[3]  = '{1'b0, 1'b1, 10'h008, 2'b00, LAT,     {1'b1, 1'b0, 10'h000, 2'b00}};
        tbl[4]  = '{1'b0, 1'b1, 10'h008, 2'b00, 1,       {1'b1, 1'b0, 10'h008, 2'b00}};
        tbl[5]  = '{1'b0, 1'b1, 10'h000, 2'b00, LAT,     {1'b1, 1'b0, 10'h008, 2'b00}};
        tbl[6]  = '{1'b0, 1'b1, 10'h000, 2'b00, 1,       {1'b1, 1'b0, 10'h000, 2'b00}};
        tbl[7]  = '{1'b0, 1'b1, 10'h2A5, 2'b00, LAT + 1, {1'b1, 1'b0, 10'h2A5, 2'b00}};
        tbl[8]  = '{1'b0, 1'b1, 10'h15A, 2'b00, LAT + 1, {1'b1, 1'b0, 10'h15A, 2'b00}};
        tbl[9]  = '{1'b1, 1'b1, 10'h15A, 2'b00, LAT,     {1'b1, 1'b0, 10'h15A, 2'b00}};
        tbl[10] = '{1'b1, 1'b1, 10'h15A, 2'b00, 1,       {1'b0, 1'b0, 10'h15A, 2'b00}};
        tbl[11] = '{1'b1, 1'b0, 10'h15A, 2'b00, LAT,     {1'b0, 1'b0, 10'h15A, 2'b00}};
        tbl[12] = '{1'b1, 1'b0, 10'h15A, 2'b00, 1,       {1'b0, 1'b1, 10'h15A, 2'b10}};
        tbl[13] = '{1'b1, 1'b1, 10'h15A, 2'b00, LAT + 1, {1'b0, 1'b0, 10'h15A, 2'b10}};
        tbl[14] = '{1'b1, 1'b0, 10'h15A, 2'b00, LAT + 1, {1'b0, 1'b1, 10'h15A, 2'b10}};
        tbl[15] = '{1'b1, 1'b0, 10'h15A, 2'b10, 1,       {1'b0, 1'b1, 10'h15A, 2'b00}};
        tbl[16] = '{1'b1, 1'b1, 10'h15A, 2'b00, LAT + 1, {1'b0, 1'b0, 10'h15A, 2'b00}};

        // Reset with KEY0 held and all switches on.
        RawButton_0 = 1'b0;
        RawButton_1 = 1'b1;
        RawSwitch   = 10'h3FF;
        EventClr    = 2'b00;
        repeat (3) step();
        check("reset_hold", outs(), 14'h0000);
        Rst = 1'b0;
        repeat (LAT) step();
        check("post_reset_early", outs(), 14'h0000);
        step();
        check("post_reset_out", outs(), {1'b1, 1'b0, 10'h3FF, 2'b01});

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            RawButton_0 = tbl[i].b0n;
            RawButton_1 = tbl[i].b1n;
            RawSwitch   = tbl[i].sw;
            EventClr    = tbl[i].clr;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Clear on the rising edge loses to the set; a later clear works.
        RawButton_0 = 1'b0;
        repeat (LAT) step();
        check("race_early", outs(), {1'b0, 1'b0, 10'h15A, 2'b00});
        EventClr = 2'b01;
        step();
        check("race_set_wins", outs(), {1'b1, 1'b0, 10'h15A, 2'b01});
        step();
        check("race_clear", outs(), {1'b1, 1'b0, 10'h15A, 2'b00});
        EventClr    = 2'b00;
        RawButton_0 = 1'b1;
        repeat (LAT + 1) step();
        check("race_release", outs(), {1'b0, 1'b0, 10'h15A, 2'b00});

`ifdef RVC_ASAP_DEBOUNCE_EN
        // A 3-cycle press is rejected.
        RawButton_1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) RawButton_1 = 1'b1;
            step();
            check($sformatf("glitch3_c%0d", k), 14'({Button_1, ButtonEvent[1]}), 14'h0000);
        end
        // A 4-cycle press is accepted. Button and event rise together.
        RawButton_1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) RawButton_1 = 1'b1;
            step();
            check($sformatf("press4_c%0d", k), 14'({Button_1, ButtonEvent[1]}),
                  (k == 5) ? 14'h0003 : 14'h0000);
        end
        repeat (LAT + 3) step();
        check("release_keeps_event", 14'({Button_1, ButtonEvent[1]}), 14'h0001);
        // Bounce train: only the final run of 4 pressed samples counts.
        for (int k = 0; k < 10; k++) begin
            RawButton_0 = (k < 8) ? pat[k][0] : 1'b0;
            step();
            check($sformatf("bounce_c%0d", k), 14'({Button_0, ButtonEvent[0]}),
                  (k >= 8) ? 14'h0003 : 14'h0000);
        end
`else
        // A 1-cycle switch pulse passes straight through after edge 2.
        RawSwitch = 10'h15B;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) RawSwitch = 10'h15A;
            check($sformatf("pulse_c%0d", k), 14'(Switch),
                  (k == 2) ? 14'h015B : 14'h015A);
        end
`endif

        // Asynchronous reset clears every output without waiting for an edge.
        #2;
        Rst = 1'b1;
        #1;
        check("async_reset", outs(), 14'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
